// File: rtl/control_sequencer_if.sv
// Control/status bundle between the instruction sequencer (master) and the datapath (slave).
interface control_sequencer_if;
    logic [15:0] op;
    logic [3:0]  modo;
    logic        flag_n;
    logic        flag_z;
    logic        mem_pronto;
    logic        io_pronto;
    logic [1:0]  sel_end;
    logic        mem_le;
    logic        mem_escreve;
    logic        carga_ri;
    logic        inc_pc;
    logic        carga_pc;
    logic        sel_pc;
    logic        carga_ac;
    logic        carga_nz;
    logic [2:0]  sel_ula;
    logic [1:0]  sel_op;
    logic        io_le;
    logic        io_escreve;
    logic        parado;
    logic        erro;

    modport master (
        input  op, modo, flag_n, flag_z, mem_pronto, io_pronto,
        output sel_end, mem_le, mem_escreve, carga_ri, inc_pc, carga_pc, sel_pc,
               carga_ac, carga_nz, sel_ula, sel_op, io_le, io_escreve, parado, erro
    );

    modport slave (
        output op, modo, flag_n, flag_z, mem_pronto, io_pronto,
        input  sel_end, mem_le, mem_escreve, carga_ri, inc_pc, carga_pc, sel_pc,
               carga_ac, carga_nz, sel_ula, sel_op, io_le, io_escreve, parado, erro
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, indirection, operand read, execute, store and I/O.
// Control outputs are decoded from the state so that load strobes follow pronto in the same cycle.
module control_sequencer (
    input  logic                clock,
    input  logic                reset_n,
    control_sequencer_if.master bus
);
    localparam int unsigned ULA_W = 3;

    localparam logic [3:0] S_INICIO = 4'd0;
    localparam logic [3:0] S_BUSCA  = 4'd1;
    localparam logic [3:0] S_DECOD  = 4'd2;
    localparam logic [3:0] S_INDIR  = 4'd3;
    localparam logic [3:0] S_OPER   = 4'd4;
    localparam logic [3:0] S_EXEC   = 4'd5;
    localparam logic [3:0] S_ESCR   = 4'd6;
    localparam logic [3:0] S_ES     = 4'd7;
    localparam logic [3:0] S_PARADO = 4'd8;
    localparam logic [3:0] S_ERRO   = 4'd9;

    localparam int unsigned OP_NOP = 15, OP_STA = 14, OP_LDA = 13, OP_ADD = 12;
    localparam int unsigned OP_SUB = 11, OP_AND = 10, OP_OR  = 9,  OP_NOT = 8;
    localparam int unsigned OP_J   = 7,  OP_JN  = 6,  OP_JZ  = 5,  OP_IN  = 4;
    localparam int unsigned OP_OUT = 3,  OP_SHR = 2,  OP_SHL = 1,  OP_HLT = 0;
    localparam int unsigned M_DIR  = 3,  M_IND  = 2,  M_IM   = 1,  M_SOP  = 0;

    // STA, LDA..OR and the three jumps take an addressing mode
    localparam logic [15:0] MODO_OPS = 16'h7EE0;
    localparam logic [15:0] JUMP_OPS = 16'h00E0;

    logic [3:0]       state, state_nx;
    logic [ULA_W-1:0] ula_q, ula_code;
    logic             imm_q, ind_q, sta_q, jmp_q, in_q;
    logic             uses_modo, is_jump, taken, bad_mode;

    // Instruction classification, only meaningful while in DECOD
    always_comb begin
        uses_modo = |(bus.op & MODO_OPS);
        is_jump   = |(bus.op & JUMP_OPS);
        taken     = bus.op[OP_J] | (bus.op[OP_JN] & bus.flag_n) | (bus.op[OP_JZ] & bus.flag_z);
        bad_mode  = uses_modo & (!$onehot(bus.modo) | bus.modo[M_SOP]
                                 | (bus.op[OP_STA] & bus.modo[M_IM]));
        ula_code  = 3'b000;
        if      (bus.op[OP_ADD]) ula_code = 3'b001;
        else if (bus.op[OP_SUB]) ula_code = 3'b010;
        else if (bus.op[OP_AND]) ula_code = 3'b011;
        else if (bus.op[OP_OR])  ula_code = 3'b100;
        else if (bus.op[OP_NOT]) ula_code = 3'b101;
        else if (bus.op[OP_SHR]) ula_code = 3'b110;
        else if (bus.op[OP_SHL]) ula_code = 3'b111;
    end

    // State register; instruction context is captured on leaving DECOD
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_INICIO;
            ula_q <= '0;
            imm_q <= 1'b0;
            ind_q <= 1'b0;
            sta_q <= 1'b0;
            jmp_q <= 1'b0;
            in_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_DECOD) begin
                ula_q <= ula_code;
                imm_q <= uses_modo & bus.modo[M_IM];
                ind_q <= bus.modo[M_IND];
                sta_q <= bus.op[OP_STA];
                jmp_q <= is_jump;
                in_q  <= bus.op[OP_IN];
            end
        end
    end

    always_comb begin
        state_nx        = state;
        bus.sel_end     = 2'b00;
        bus.mem_le      = 1'b0;
        bus.mem_escreve = 1'b0;
        bus.carga_ri    = 1'b0;
        bus.inc_pc      = 1'b0;
        bus.carga_pc    = 1'b0;
        bus.sel_pc      = 1'b0;
        bus.carga_ac    = 1'b0;
        bus.carga_nz    = 1'b0;
        bus.sel_ula     = 3'b000;
        bus.sel_op      = 2'b00;
        bus.io_le       = 1'b0;
        bus.io_escreve  = 1'b0;
        bus.parado      = 1'b0;
        bus.erro        = 1'b0;

        case (state)
            S_INICIO: state_nx = S_BUSCA;
            S_BUSCA: begin
                bus.mem_le = 1'b1;
                if (bus.mem_pronto) begin
                    bus.carga_ri = 1'b1;
                    bus.inc_pc   = 1'b1;
                    state_nx     = S_DECOD;
                end
            end
            S_DECOD: begin
                if (!$onehot(bus.op) || bad_mode)                    state_nx = S_ERRO;
                else if (bus.op[OP_NOP])                             state_nx = S_BUSCA;
                else if (bus.op[OP_HLT])                             state_nx = S_PARADO;
                else if (bus.op[OP_NOT] | bus.op[OP_SHR] | bus.op[OP_SHL]) state_nx = S_EXEC;
                else if (bus.op[OP_IN] | bus.op[OP_OUT])             state_nx = S_ES;
                else if (is_jump && !taken)                          state_nx = S_BUSCA;
                else if (bus.modo[M_IND])                            state_nx = S_INDIR;
                else if (is_jump) begin
                    bus.carga_pc = 1'b1;
                    state_nx     = S_BUSCA;
                end
                else if (bus.op[OP_STA])                             state_nx = S_ESCR;
                else if (bus.modo[M_DIR])                            state_nx = S_OPER;
                else                                                 state_nx = S_EXEC;
            end
            S_INDIR: begin
                bus.mem_le  = 1'b1;
                bus.sel_end = 2'b01;
                if (bus.mem_pronto) begin
                    if (jmp_q) begin
                        bus.carga_pc = 1'b1;
                        bus.sel_pc   = 1'b1;
                        state_nx     = S_BUSCA;
                    end
                    else if (sta_q) state_nx = S_ESCR;
                    else            state_nx = S_OPER;
                end
            end
            S_OPER: begin
                bus.mem_le  = 1'b1;
                bus.sel_end = ind_q ? 2'b10 : 2'b01;
                if (bus.mem_pronto) state_nx = S_EXEC;
            end
            S_EXEC: begin
                bus.carga_ac = 1'b1;
                bus.carga_nz = 1'b1;
                bus.sel_ula  = ula_q;
                bus.sel_op   = imm_q ? 2'b01 : 2'b00;
                state_nx     = S_BUSCA;
            end
            S_ESCR: begin
                bus.mem_escreve = 1'b1;
                bus.sel_end     = ind_q ? 2'b10 : 2'b01;
                if (bus.mem_pronto) state_nx = S_BUSCA;
            end
            S_ES: begin
                bus.io_le      = in_q;
                bus.io_escreve = !in_q;
                if (bus.io_pronto) begin
                    bus.carga_ac = in_q;
                    bus.carga_nz = in_q;
                    bus.sel_op   = in_q ? 2'b10 : 2'b00;
                    state_nx     = S_BUSCA;
                end
            end
            S_PARADO: bus.parado = 1'b1;
            S_ERRO: begin
                bus.parado = 1'b1;
                bus.erro   = 1'b1;
            end
            default: state_nx = S_ERRO;
        endcase
    end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clock, input, 1 bit: single system clock; all state changes occur on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port op, input, 16 bits: one-hot decoded operation, with bit 15 down to bit 0 = NOP, STA, LDA, ADD, SUB, AND, OR, NOT, J, JN, JZ, IN, OUT, SHR, SHL, HLT.
REQ-004 SHALL have port modo, input, 4 bits: one-hot addressing mode, with bit 3 down to bit 0 = DIR, IND, IM, SOP.
REQ-005 SHALL have port flag_n, input, 1 bit, and port flag_z, input, 1 bit: accumulator negative and zero flags.
REQ-006 SHALL have port mem_pronto, input, 1 bit: memory transfer complete, and port io_pronto, input, 1 bit: I/O transfer complete.
REQ-007 SHALL have port sel_end, output, 2 bits: memory address select; 00 = PC, 01 = instruction field [8:0], 10 = data register (indirect pointer).
REQ-008 SHALL have port mem_le, output, 1 bit: memory read request, and port mem_escreve, output, 1 bit: memory write request.
REQ-009 SHALL have outputs carga_ri (load instruction register), inc_pc (increment PC), carga_pc (load PC) and sel_pc (PC source; 0 = field, 1 = data register); each is 1 bit.
REQ-010 SHALL have outputs carga_ac (1 bit), carga_nz (1 bit), sel_ula (3 bits) and sel_op (2 bits).
REQ-011 SHALL encode sel_ula as: 000 = pass B, 001 = ADD, 010 = SUB, 011 = AND, 100 = OR, 101 = NOT, 110 = SHR, 111 = SHL.
REQ-012 SHALL encode sel_op (ALU operand B source) as: 00 = memory data, 01 = zero-extended field, 10 = I/O input.
REQ-013 SHALL have outputs io_le, io_escreve, parado and erro, each 1 bit.

Function
REQ-014 SHALL implement these states: INICIO, BUSCA, DECOD, INDIR, OPER, EXEC, ESCR, ES, PARADO, ERRO.
REQ-015 SHALL hold the request strobe and sel_end stable in every wait state (BUSCA, INDIR, OPER, ESCR, ES) until the matching pronto input is sampled high.
REQ-016 SHALL assert load strobes (carga_*, inc_pc) combinationally in the cycle the pronto input is high, and SHALL ignore pronto inputs in all other states.
REQ-017 INICIO SHALL drive all outputs to 0 and SHALL go to BUSCA on the next edge.
REQ-018 BUSCA SHALL drive mem_le=1 with sel_end=00; on mem_pronto it SHALL assert carga_ri and inc_pc and go to DECOD.
REQ-019 DECOD SHALL go to ERRO when op is not exactly one-hot, or when modo is not one-hot for an operation that uses modo.
REQ-020 DECOD SHALL go to ERRO for STA with IM or SOP, and for LDA, ADD, SUB, AND, OR, J, JN or JZ with SOP.
REQ-021 NOP, NOT, SHR, SHL, IN, OUT and HLT SHALL ignore modo.
REQ-022 DECOD, for NOP, SHALL go to BUSCA; for HLT, SHALL go to PARADO.
REQ-023 DECOD, for NOT, SHR and SHL, SHALL go to EXEC; for IN and OUT, SHALL go to ES.
REQ-024 DECOD, for any operation with IND, SHALL go to INDIR.
REQ-025 DECOD, for LDA/ADD/SUB/AND/OR, SHALL go to OPER when DIR and to EXEC when IM; for STA with DIR, SHALL go to ESCR.
REQ-026 DECOD, for a jump that is taken (J always; JN when flag_n=1; JZ when flag_z=1) with DIR or IM, SHALL assert carga_pc with sel_pc=0 and go to BUSCA.
REQ-027 DECOD, for a jump that is not taken, SHALL go to BUSCA with no PC load, regardless of mode.
REQ-028 INDIR SHALL drive mem_le=1 with sel_end=01; on mem_pronto it SHALL go to ESCR for STA and to OPER for ALU operations.
REQ-029 INDIR, on mem_pronto for a jump, SHALL assert carga_pc with sel_pc=1 and go to BUSCA.
REQ-030 OPER SHALL drive mem_le=1 with sel_end=01 after DIR and sel_end=10 after IND; on mem_pronto it SHALL go to EXEC.
REQ-031 EXEC SHALL assert carga_ac and carga_nz for exactly one cycle with the matching sel_ula (LDA uses 000), then go to BUSCA.
REQ-032 EXEC SHALL drive sel_op=01 for IM operands and sel_op=00 for all other operands.
REQ-033 ESCR SHALL drive mem_escreve=1 with sel_end=01 after DIR and sel_end=10 after IND; on mem_pronto it SHALL go to BUSCA.
REQ-034 ES SHALL drive io_le=1 for IN; on io_pronto it SHALL assert carga_ac and carga_nz with sel_op=10 and sel_ula=000.
REQ-035 ES SHALL drive io_escreve=1 for OUT; on io_pronto it SHALL go to BUSCA (also after an IN completes).
REQ-036 PARADO SHALL drive parado=1; ERRO SHALL drive parado=1 and erro=1; both states SHALL be exited only by reset.
REQ-037 SHALL give these cycle counts (pronto always high): NOT = 3; LDA IM = 3; LDA DIR = 4; LDA IND = 5; STA DIR = 3; J DIR = 2; J IND = 3.

Reset
REQ-038 SHALL, while reset_n=0, force state INICIO and drive all outputs to 0 immediately, regardless of clock.
REQ-039 SHALL treat reset asserted mid-operation (including inside a wait state) as an abort: the request drops immediately, no load strobe is issued, and the sequencer restarts at INICIO.

Verification
REQ-040 SHALL cover: release reset -> one idle cycle, then mem_le=1 with sel_end=00; hold mem_pronto=0 for 5 cycles -> mem_le stays 1 and carga_ri stays 0.
REQ-041 SHALL cover: ADD IND with pronto tied high -> states BUSCA, DECOD, INDIR, OPER, EXEC; carga_ac=1 for one cycle with sel_ula=001 and sel_op=00.
REQ-042 SHALL cover: JZ DIR with flag_z=0 -> no carga_pc, back to BUSCA after 2 cycles; the same with flag_z=1 -> carga_pc=1 and sel_pc=0 in DECOD.
REQ-043 SHALL cover: STA with modo=0010 (IM) -> erro=1 and parado=1 held for 20 cycles; reset then clears both.
REQ-044 SHALL cover: IN with io_pronto delayed 3 cycles -> io_le=1 for 4 cycles; carga_ac with sel_op=10 only in the io_pronto cycle.
REQ-045 SHALL cover: reset_n pulsed low during OPER -> mem_le falls before the next clock edge and no carga_ac is issued.
